s_aes_iter_core: RTL and testbench

S_AES_ITER_CORE -- requirements
Module: s_aes_iter_core

---
 rtl/s_aes_pkg.sv | 75 +++++++
 rtl/s_aes_key_sched.sv | 24 ++
 rtl/s_aes_iter_core.sv | 147 ++++++++++++++
 tb/tb_s_aes_iter_core.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s_aes_pkg.sv
// Shared S-AES definitions: FSM states, nibble S-boxes, round constants
// and the GF(2^4) round helpers used by the key schedule and the core.
package s_aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RND1 = 2'd1,
        RND2 = 2'd2
    } state_e;

    typedef struct packed {
        logic        mode;
        logic [15:0] data;
    } out_entry_t;

    localparam logic [7:0] RCON1 = 8'h80;
    localparam logic [7:0] RCON2 = 8'h30;

    localparam logic [3:0] SBOX [16] = '{
        4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
        4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
        4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE
    };

    // Shift-and-add multiply, reducing by x^4+x+1 on every doubling.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [7:0] sub_nib8(input logic [7:0] w);
        return {SBOX[w[7:4]], SBOX[w[3:0]]};
    endfunction

    function automatic logic [7:0] rot_nib8(input logic [7:0] w);
        return {w[3:0], w[7:4]};
    endfunction

    function automatic logic [15:0] sub16(input logic [15:0] s);
        return {SBOX[s[15:12]], SBOX[s[11:8]], SBOX[s[7:4]], SBOX[s[3:0]]};
    endfunction

    function automatic logic [15:0] inv_sub16(input logic [15:0] s);
        return {INV_SBOX[s[15:12]], INV_SBOX[s[11:8]], INV_SBOX[s[7:4]], INV_SBOX[s[3:0]]};
    endfunction

    // Nibbles 2 and 4 form the bottom row; swapping them is its own inverse.
    function automatic logic [15:0] shift_row(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [15:0] mix_col(input logic [15:0] s);
        return {s[15:12] ^ gf_mul(4'h4, s[11:8]), gf_mul(4'h4, s[15:12]) ^ s[11:8],
                s[7:4]   ^ gf_mul(4'h4, s[3:0]),  gf_mul(4'h4, s[7:4])   ^ s[3:0]};
    endfunction

    function automatic logic [15:0] inv_mix_col(input logic [15:0] s);
        return {gf_mul(4'h9, s[15:12]) ^ gf_mul(4'h2, s[11:8]),
                gf_mul(4'h2, s[15:12]) ^ gf_mul(4'h9, s[11:8]),
                gf_mul(4'h9, s[7:4])   ^ gf_mul(4'h2, s[3:0]),
                gf_mul(4'h2, s[7:4])   ^ gf_mul(4'h9, s[3:0])};
    endfunction

endpackage

// File: rtl/s_aes_key_sched.sv
// Combinational S-AES key expansion: 16-bit key -> three 16-bit round keys.
module s_aes_key_sched
    import s_aes_pkg::*;
(
    input  logic [15:0] key_i,
    output logic [15:0] k0_o,
    output logic [15:0] k1_o,
    output logic [15:0] k2_o
);

    logic [7:0] w0, w1, w2, w3, w4, w5;

    assign w0 = key_i[15:8];
    assign w1 = key_i[7:0];
    assign w2 = w0 ^ RCON1 ^ sub_nib8(rot_nib8(w1));
    assign w3 = w2 ^ w1;
    assign w4 = w2 ^ RCON2 ^ sub_nib8(rot_nib8(w3));
    assign w5 = w4 ^ w3;

    assign k0_o = {w0, w1};
    assign k1_o = {w2, w3};
    assign k2_o = {w4, w5};

endmodule

// File: rtl/s_aes_iter_core.sv
// Iterative S-AES encrypt/decrypt core: one block per 3 cycles, result at the head of
// a small output FIFO; a full FIFO stalls the FSM in RND2 and drops in_ready.
module s_aes_iter_core
    import s_aes_pkg::*;
#(
    parameter int OUT_DEPTH = 2,
    parameter bit RST_FLUSH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [15:0] in_data,
    input  logic [15:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_mode,
    output logic        busy
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int PW = AW + 1;

    state_e      state_q, state_d;
    logic        mode_q, mode_d;
    logic [15:0] st_q, st_d;
    logic [15:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d;
    logic [15:0] k0_w, k1_w, k2_w;
    logic [15:0] result;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    out_entry_t  mem_q [OUT_DEPTH];
    logic        accept, in_rnd2, full, empty, pop, push_ok, push;

    s_aes_key_sched u_key_sched (
        .key_i (in_key),
        .k0_o  (k0_w),
        .k1_o  (k1_w),
        .k2_o  (k2_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RND1;
            RND1:    state_d = RND2;
            RND2:    if (push_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
        in_rnd2  = (state_q == RND2);
        busy     = (state_q != IDLE) || !empty;
    end

    assign accept  = in_valid && in_ready;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && out_ready;
    assign push_ok = !full || pop;
    assign push    = in_rnd2 && push_ok;

    always_comb begin
        mode_d = mode_q;
        st_d   = st_q;
        k0_d   = k0_q;
        k1_d   = k1_q;
        k2_d   = k2_q;
        if (accept) begin
            mode_d = in_mode;
            k0_d   = k0_w;
            k1_d   = k1_w;
            k2_d   = k2_w;
            st_d   = in_data ^ (in_mode ? k0_w : k2_w);
        end else if (state_q == RND1) begin
            st_d = mode_q ? (mix_col(shift_row(sub16(st_q))) ^ k1_q)
                          : inv_mix_col(inv_sub16(shift_row(st_q)) ^ k1_q);
        end
    end

    // The final round is evaluated straight into the FIFO, so a stall just holds st_q.
    assign result = mode_q ? (shift_row(sub16(st_q)) ^ k2_q)
                           : (inv_sub16(shift_row(st_q)) ^ k0_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            st_q   <= '0;
            k0_q   <= '0;
            k1_q   <= '0;
            k2_q   <= '0;
        end else begin
            mode_q <= mode_d;
            st_q   <= st_d;
            k0_q   <= k0_d;
            k1_q   <= k1_d;
            k2_q   <= k2_d;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    generate
        if (RST_FLUSH) begin : g_flush
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
                end else if (push) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= '{mode: mode_q, data: result};
                end
            end
        end else begin : g_noflush
            always_ff @(posedge clk) begin
                if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{mode: mode_q, data: result};
            end
        end
    endgenerate

    // Outputs read 0 whenever the FIFO is empty, so unflushed storage never leaks out.
    assign out_valid = !empty;
    assign out_data  = empty ? 16'h0 : mem_q[rd_ptr_q[AW-1:0]].data;
    assign out_mode  = empty ? 1'b0  : mem_q[rd_ptr_q[AW-1:0]].mode;

endmodule

// File: tb/tb_s_aes_iter_core.sv
// Self-checking bench for s_aes_iter_core: known S-AES vectors, backpressure, reset
// and randomized back-to-back traffic against a matrix-level S-AES model.
module tb_s_aes_iter_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [15:0] in_data = '0;
    logic [15:0] in_key = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_mode;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    int sb  [16] = '{9, 4, 10, 11, 13, 1, 8, 5, 6, 2, 0, 3, 12, 14, 15, 7};
    int isb [16] = '{10, 5, 9, 11, 1, 7, 8, 15, 6, 0, 2, 3, 12, 4, 13, 14};

    s_aes_iter_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Polynomial product, then long division by x^4+x+1 (0x13).
    function automatic int gmul(input int a, input int b);
        int p = 0;
        for (int i = 0; i < 4; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int i = 6; i >= 4; i--) if (((p >> i) & 1) != 0) p = p ^ ('h13 << (i - 4));
        return p;
    endfunction

    function automatic int sub_word(input int w);
        return (sb[(w >> 4) & 15] << 4) | sb[w & 15];
    endfunction

    function automatic int rot_word(input int w);
        return ((w & 15) << 4) | ((w >> 4) & 15);
    endfunction

    // State as a 2x2 nibble matrix in column order: s[0]=r0c0, s[1]=r1c0, s[2]=r0c1, s[3]=r1c1.
    function automatic logic [15:0] ref_saes(input logic enc, input logic [15:0] data, input logic [15:0] key);
        int w [6];
        int rk [3];
        int s [4];
        int a, b, t, m0, m1, r;
        w[0] = int'(key[15:8]);
        w[1] = int'(key[7:0]);
        w[2] = w[0] ^ 'h80 ^ sub_word(rot_word(w[1]));
        w[3] = w[2] ^ w[1];
        w[4] = w[2] ^ 'h30 ^ sub_word(rot_word(w[3]));
        w[5] = w[4] ^ w[3];
        for (int k = 0; k < 3; k++) rk[k] = (w[2*k] << 8) | w[2*k+1];
        t = int'(data) ^ (enc ? rk[0] : rk[2]);
        for (int i = 0; i < 4; i++) s[i] = (t >> (12 - 4*i)) & 15;
        m0 = enc ? 1 : 9;
        m1 = enc ? 4 : 2;
        if (enc) begin
            for (int i = 0; i < 4; i++) s[i] = sb[s[i]];
            t = s[1]; s[1] = s[3]; s[3] = t;
            for (int c = 0; c < 2; c++) begin
                a = s[2*c]; b = s[2*c+1];
                s[2*c]   = gmul(m0, a) ^ gmul(m1, b);
                s[2*c+1] = gmul(m1, a) ^ gmul(m0, b);
            end
            for (int i = 0; i < 4; i++) s[i] = s[i] ^ ((rk[1] >> (12 - 4*i)) & 15);
            for (int i = 0; i < 4; i++) s[i] = sb[s[i]];
            t = s[1]; s[1] = s[3]; s[3] = t;
            for (int i = 0; i < 4; i++) s[i] = s[i] ^ ((rk[2] >> (12 - 4*i)) & 15);
        end else begin
            t = s[1]; s[1] = s[3]; s[3] = t;
            for (int i = 0; i < 4; i++) s[i] = isb[s[i]];
            for (int i = 0; i < 4; i++) s[i] = s[i] ^ ((rk[1] >> (12 - 4*i)) & 15);
            for (int c = 0; c < 2; c++) begin
                a = s[2*c]; b = s[2*c+1];
                s[2*c]   = gmul(m0, a) ^ gmul(m1, b);
                s[2*c+1] = gmul(m1, a) ^ gmul(m0, b);
            end
            t = s[1]; s[1] = s[3]; s[3] = t;
            for (int i = 0; i < 4; i++) s[i] = isb[s[i]];
            for (int i = 0; i < 4; i++) s[i] = s[i] ^ ((rk[0] >> (12 - 4*i)) & 15);
        end
        r = 0;
        for (int i = 0; i < 4; i++) r = (r << 4) | s[i];
        return 16'(r);
    endfunction

    // Offer one block, wait (bounded) for the accept edge, then scramble the inputs.
    task automatic send(input logic m, input logic [15:0] d, input logic [15:0] k);
        int n = 0;
        in_valid = 1'b1; in_mode = m; in_data = d; in_key = k;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
            fails++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_mode = ~m; in_data = 16'($urandom); in_key = 16'($urandom);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, out_mode, out_data} !== 20'h0) begin
            $display("FAIL reset_outputs: rdy=%0b ov=%0b busy=%0b mode=%0b data=%h, required all 0",
                     in_ready, out_valid, busy, out_mode, out_data);
            fails++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_release: in_ready=%0b busy=%0b, required 1/0", in_ready, busy);
            fails++;
        end
    endtask

    task automatic test_decrypt_vector();
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(1'b0, 16'h24EC, 16'h4AF5);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (c < 3 && out_valid !== 1'b0) begin
                $display("FAIL dec_latency: out_valid=%0b at cycle %0d, required 0", out_valid, c);
                fails++;
            end else if (c == 3 && {out_valid, out_mode, out_data} !== {1'b1, 1'b0, 16'hD728}) begin
                $display("FAIL dec_vector: ov=%0b mode=%0b data=%h, required 1/0/d728", out_valid, out_mode, out_data);
                fails++;
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL dec_drain: out_valid=%0b busy=%0b, required 0/0", out_valid, busy);
            fails++;
        end
    endtask

    task automatic test_encrypt_roundtrip();
        out_ready = 1'b1;
        send(1'b1, 16'h6F6B, 16'hA73B);
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_mode, out_data} !== {1'b1, 1'b1, 16'h0738}) begin
            $display("FAIL enc_vector: ov=%0b mode=%0b data=%h, required 1/1/0738", out_valid, out_mode, out_data);
            fails++;
        end
        @(posedge clk); #1;
        send(1'b0, 16'h0738, 16'hA73B);
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_mode, out_data} !== {1'b1, 1'b0, 16'h6F6B}) begin
            $display("FAIL dec_roundtrip: ov=%0b mode=%0b data=%h, required 1/0/6f6b", out_valid, out_mode, out_data);
            fails++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [15:0] d [3];
        logic [15:0] k [3];
        logic        m [3];
        logic [15:0] e [3];
        for (int i = 0; i < 3; i++) begin
            d[i] = 16'($urandom); k[i] = 16'($urandom); m[i] = (i != 1);
            e[i] = ref_saes(m[i], d[i], k[i]);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(m[i], d[i], k[i]);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({in_ready, busy, out_valid, out_mode, out_data} !== {1'b0, 1'b1, 1'b1, m[0], e[0]}) begin
                $display("FAIL bp_stall: rdy=%0b busy=%0b ov=%0b mode=%0b data=%h, required 0/1/1/%0b/%h",
                         in_ready, busy, out_valid, out_mode, out_data, m[0], e[0]);
                fails++;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_mode, out_data} !== {1'b1, 1'b1, m[1], e[1]}) begin
            $display("FAIL bp_pop_push: rdy=%0b ov=%0b mode=%0b data=%h, required 1/1/%0b/%h",
                     in_ready, out_valid, out_mode, out_data, m[1], e[1]);
            fails++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 1; i < 3; i++) begin
            checks++;
            if ({out_valid, out_mode, out_data} !== {1'b1, m[i], e[i]}) begin
                $display("FAIL bp_order_%0d: ov=%0b mode=%0b data=%h, required 1/%0b/%h",
                         i, out_valid, out_mode, out_data, m[i], e[i]);
                fails++;
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL bp_empty: out_valid=%0b busy=%0b, required 0/0", out_valid, busy);
            fails++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int seen = 0;
        out_ready = 1'b0;
        send(1'b1, 16'h1234, 16'h5678);
        repeat (2) @(posedge clk);
        #1;
        send(1'b0, 16'h9ABC, 16'hDEF0);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL rst_mid_op: ov=%0b busy=%0b rdy=%0b, required 0/0/0", out_valid, busy, in_ready);
            fails++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            $display("FAIL rst_stale: out_valid high for %0d cycles, required 0", seen);
            fails++;
        end
        @(posedge clk); #1;
        send(1'b0, 16'h24EC, 16'h4AF5);
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_mode, out_data} !== {1'b1, 1'b0, 16'hD728}) begin
            $display("FAIL rst_recover: ov=%0b mode=%0b data=%h, required 1/0/d728", out_valid, out_mode, out_data);
            fails++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        localparam int NBLK = 48;
        logic [15:0] exp_d [$];
        logic        exp_m [$];
        int   sent = 0, got = 0, cyc = 0;
        logic cur_m = 1'b0;
        bit   acc;
        in_valid = 1'b1; in_mode = cur_m; in_data = 16'($urandom); in_key = 16'($urandom);
        while ((sent < NBLK || exp_d.size() > 0) && cyc < 3000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (exp_d.size() == 0) begin
                    $display("FAIL b2b_extra: unexpected result %h", out_data);
                    fails++;
                end else if (out_data !== exp_d[0] || out_mode !== exp_m[0]) begin
                    $display("FAIL b2b_data: block %0d got %h/%0b, required %h/%0b",
                             got, out_data, out_mode, exp_d[0], exp_m[0]);
                    fails++;
                end
                if (out_ready && exp_d.size() > 0) begin
                    void'(exp_d.pop_front());
                    void'(exp_m.pop_front());
                    got++;
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                exp_d.push_back(ref_saes(in_mode, in_data, in_key));
                exp_m.push_back(in_mode);
                sent++;
            end
            @(posedge clk); #1;
            if (acc) begin
                cur_m = ~cur_m;
                in_valid = (sent < NBLK);
                in_mode = cur_m; in_data = 16'($urandom); in_key = 16'($urandom);
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != NBLK || exp_d.size() != 0) begin
            $display("FAIL b2b_count: popped %0d, %0d outstanding, required %0d/0", got, exp_d.size(), NBLK);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_decrypt_vector();
        test_encrypt_roundtrip();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
